// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR conversion sequencer.
package sar_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StHold
    } sar_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/sar_conv_sequencer_if.sv
// SAR-side handshake (cnvst/eoc/sar) and result stream (dout/valid/ready).
interface sar_conv_sequencer_if #(
    parameter int unsigned DATA_W = sar_pkg::DATA_W_DEF
);
    logic              cnvst;
    logic              eoc;
    logic [DATA_W-1:0] sar;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output cnvst, dout, dout_valid,
        input  eoc, sar, dout_ready
    );

    modport slave (
        input  cnvst, dout, dout_valid,
        output eoc, sar, dout_ready
    );
endinterface

// File: rtl/sar_result_fifo.sv
// Synchronous result FIFO with a registered head; a push when full and not popped is dropped.
module sar_result_fifo
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int unsigned AW = clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && !push_ok;
    assign head_o  = head_q;

    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, push_ok};
        rd_d = rd_q + {{AW{1'b0}}, pop_ok};
        // Head tracks the post-update memory so dout is ready the cycle after a push.
        if (push_ok && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
            head_d = din_i;
        end else begin
            head_d = mem_q[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
            if (push_ok) begin
                mem_q[wr_q[AW-1:0]] <= din_i;
            end
        end
    end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Periodic SAR conversion initiator with result FIFO and sticky error flags.
// Define SAR_AVG4_EN to push the mean of every 4 completed conversions instead of raw results.
module sar_conv_sequencer
    import sar_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned PER_W      = 8,
    parameter int unsigned CNVST_W    = 2,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic [PER_W-1:0]            period_i,
    input  logic                        clr_i,
    sar_conv_sequencer_if.master        bus_io,
    output logic                        overrun_o,
    output logic                        timeout_err_o,
    output logic                        busy_o
);
    localparam int unsigned CYC_MAX = (TIMEOUT > CNVST_W) ? TIMEOUT : CNVST_W;
    localparam int unsigned CYC_W   = clog2(CYC_MAX + 1);

    sar_state_e        state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic              cnvst_q, cnvst_d;
    logic              eoc_q;
    logic              overrun_q, timeout_q;
    logic              eoc_rise, complete, tmo_set, idle_entry;
    logic              push, fifo_full, fifo_empty, fifo_drop, pop;
    logic [DATA_W-1:0] push_data, fifo_head;

    assign eoc_rise = bus_io.eoc & ~eoc_q;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        per_d    = (per_q == '1) ? per_q : per_q + 1'b1;
        complete = 1'b0;
        tmo_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en_i) state_d = StStart;
            end
            StStart: begin
                if (cyc_q == CYC_W'(CNVST_W - 1)) begin
                    state_d = StWait;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StWait: begin
                if (eoc_rise) begin
                    complete = 1'b1;
                    state_d  = StHold;
                end else if (cyc_q == CYC_W'(TIMEOUT - 1)) begin
                    tmo_set = 1'b1;
                    state_d = StHold;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StHold: begin
                if (!en_i) begin
                    state_d = StIdle;
                end else if (per_q >= period_i) begin
                    state_d = StStart;
                end
            end
            default: state_d = StIdle;
        endcase
        if ((state_d == StStart) && (state_q != StStart)) begin
            per_d = PER_W'(1);
            cyc_d = '0;
        end
        cnvst_d    = (state_d == StStart);
        idle_entry = (state_d == StIdle) && (state_q != StIdle);
    end

`ifdef SAR_AVG4_EN
    logic [DATA_W+1:0] acc_q, acc_d, acc_sum;
    logic [1:0]        avg_cnt_q, avg_cnt_d;

    always_comb begin
        acc_sum   = acc_q + {2'b00, bus_io.sar};
        acc_d     = acc_q;
        avg_cnt_d = avg_cnt_q;
        push      = 1'b0;
        push_data = acc_sum[DATA_W+1:2];
        if (idle_entry) begin
            acc_d     = '0;
            avg_cnt_d = '0;
        end else if (complete) begin
            if (avg_cnt_q == 2'd3) begin
                push      = 1'b1;
                acc_d     = '0;
                avg_cnt_d = '0;
            end else begin
                acc_d     = acc_sum;
                avg_cnt_d = avg_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            avg_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            avg_cnt_q <= avg_cnt_d;
        end
    end
`else
    assign push      = complete;
    assign push_data = bus_io.sar;
`endif

    assign pop = bus_io.dout_ready;

    sar_result_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .din_i   (push_data),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop),
        .head_o  (fifo_head)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            per_q     <= '0;
            cnvst_q   <= 1'b0;
            eoc_q     <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            per_q     <= per_d;
            cnvst_q   <= cnvst_d;
            eoc_q     <= bus_io.eoc;
            // Set beats a coincident clear.
            overrun_q <= fifo_drop | (overrun_q & ~clr_i);
            timeout_q <= tmo_set | (timeout_q & ~clr_i);
        end
    end

    assign bus_io.cnvst      = cnvst_q;
    assign bus_io.dout       = fifo_head;
    assign bus_io.dout_valid = ~fifo_empty;
    assign overrun_o         = overrun_q;
    assign timeout_err_o     = timeout_q;
    assign busy_o            = (state_q != StIdle);

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed bench for sar_conv_sequencer with a behavioural sar_logic model.
module tb_sar_conv_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [7:0] period;
    logic       overrun, timeout_err, busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // sar_logic model state
    int         dly = 0;
    int         mcnt;
    int         nconv;
    int         eoc_cyc;
    logic       cprev;
    logic [7:0] sar_seq [16];

    sar_conv_sequencer_if #(.DATA_W(8)) bus ();

    sar_conv_sequencer dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .en_i          (en),
        .period_i      (period),
        .clr_i         (clr),
        .bus_io        (bus),
        .overrun_o     (overrun),
        .timeout_err_o (timeout_err),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Raises eoc for one cycle dly cycles after each cnvst fall; dly=0 never answers.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.eoc = 1'b0;
            bus.sar = 8'h00;
            mcnt    = 0;
            nconv   = 0;
            cprev   = 1'b0;
        end else begin
            bus.eoc = 1'b0;
            if (cprev && !bus.cnvst) begin
                mcnt = dly;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    bus.eoc = 1'b1;
                    bus.sar = sar_seq[nconv % 16];
                    nconv++;
                    eoc_cyc = cyc;
                end
            end
            cprev = bus.cnvst;
        end
    end

    typedef struct {
        int         per;
        int         d;
        logic [7:0] val;
        int         exp_gap;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.cnvst;
            1:       return bus.dout_valid;
            default: return timeout_err;
        endcase
    endfunction

    task automatic wait_sig(input string nm, input int which, input logic lvl, output int t);
        t = -1000;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sig(which) === lvl) begin
                t = cyc;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL %s: timed out, required level %0d", nm, lvl);
    endtask

    task automatic wait_nconv(input int n);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (nconv >= n) return;
        end
        tests++;
        fails++;
        $display("FAIL wait_nconv: got %0d conversions, required %0d", nconv, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        en             = 1'b0;
        clr            = 1'b0;
        bus.dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int t_r1, t_f, t_v, t_r2, t_e, rises;

        vecs[0] = '{per: 40, d: 10, val: 8'hA5, exp_gap: 40};
        vecs[1] = '{per: 0,  d: 5,  val: 8'h3C, exp_gap: 9};
        vecs[2] = '{per: 8,  d: 10, val: 8'hFF, exp_gap: 14};
        vecs[3] = '{per: 20, d: 3,  val: 8'h00, exp_gap: 20};
        vecs[4] = '{per: 14, d: 10, val: 8'h5A, exp_gap: 14};

        rst_n          = 1'b0;
        en             = 1'b0;
        clr            = 1'b0;
        period         = 8'd0;
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 16; i++) sar_seq[i] = 8'h00;
        do_reset();

        check("reset_flags", {bus.cnvst, bus.dout_valid, overrun, timeout_err, busy}, 0);
        check("reset_dout", bus.dout, 0);

`ifdef SAR_AVG4_EN
        sar_seq[0] = 8'd10;
        sar_seq[1] = 8'd11;
        sar_seq[2] = 8'd12;
        sar_seq[3] = 8'd14;
        period     = 8'd20;
        dly        = 3;
        en         = 1'b1;
        wait_nconv(3);
        repeat (3) @(negedge clk);
        check("avg_no_push_yet", bus.dout_valid, 0);
        wait_nconv(4);
        repeat (2) @(negedge clk);
        en = 1'b0;
        check("avg_valid", bus.dout_valid, 1);
        check("avg_dout", bus.dout, 11);
        bus.dout_ready = 1'b1;
        @(negedge clk);
        bus.dout_ready = 1'b0;
        check("avg_single_entry", bus.dout_valid, 0);
`else
        // Table: cnvst width, result latency/value and cnvst period for several configurations.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            period     = vecs[v].per[7:0];
            dly        = vecs[v].d;
            sar_seq[0] = vecs[v].val;
            sar_seq[1] = vecs[v].val;
            en         = 1'b1;
            wait_sig("vec_rise1", 0, 1'b1, t_r1);
            check("vec_busy", busy, 1);
            wait_sig("vec_fall", 0, 1'b0, t_f);
            check("vec_cnvst_width", t_f - t_r1, 2);
            wait_sig("vec_valid", 1, 1'b1, t_v);
            check("vec_valid_latency", t_v - eoc_cyc, 1);
            check("vec_dout", bus.dout, vecs[v].val);
            wait_sig("vec_rise2", 0, 1'b1, t_r2);
            check("vec_gap", t_r2 - t_r1, vecs[v].exp_gap);
            en = 1'b0;
        end

        // Overrun: five results into a 4-deep FIFO with no consumer.
        do_reset();
        for (int i = 0; i < 5; i++) sar_seq[i] = 8'(i + 1);
        period = 8'd20;
        dly    = 3;
        en     = 1'b1;
        wait_nconv(4);
        repeat (2) @(negedge clk);
        check("ovr_before_5th", overrun, 0);
        wait_nconv(5);
        repeat (2) @(negedge clk);
        en = 1'b0;
        check("ovr_after_5th", overrun, 1);
        for (int i = 0; i < 4; i++) begin
            check("ovr_drain_valid", bus.dout_valid, 1);
            check("ovr_drain_data", bus.dout, i + 1);
            bus.dout_ready = 1'b1;
            @(negedge clk);
        end
        bus.dout_ready = 1'b0;
        check("ovr_drained_empty", bus.dout_valid, 0);
        check("ovr_still_set", overrun, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("ovr_cleared", overrun, 0);

        // Timeout: model never answers.
        do_reset();
        period = 8'd100;
        dly    = 0;
        en     = 1'b1;
        wait_sig("tmo_rise1", 0, 1'b1, t_r1);
        wait_sig("tmo_fall", 0, 1'b0, t_f);
        wait_sig("tmo_flag", 2, 1'b1, t_e);
        check("tmo_latency", t_e - t_f, 64);
        check("tmo_no_push", bus.dout_valid, 0);
        wait_sig("tmo_rise2", 0, 1'b1, t_r2);
        check("tmo_next_cnvst", t_r2 - t_r1, 100);
        en  = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("tmo_cleared", timeout_err, 0);

        // en dropped while waiting for eoc.
        do_reset();
        period     = 8'd30;
        dly        = 10;
        sar_seq[0] = 8'h77;
        en         = 1'b1;
        wait_sig("endrop_rise", 0, 1'b1, t_r1);
        wait_sig("endrop_fall", 0, 1'b0, t_f);
        en = 1'b0;
        wait_sig("endrop_valid", 1, 1'b1, t_v);
        check("endrop_dout", bus.dout, 8'h77);
        repeat (2) @(negedge clk);
        check("endrop_idle", busy, 0);
        rises = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.cnvst) rises++;
        end
        check("endrop_no_cnvst", rises, 0);

        // Asynchronous reset during START with a result already queued.
        do_reset();
        period     = 8'd40;
        dly        = 5;
        sar_seq[0] = 8'h11;
        en         = 1'b1;
        wait_sig("arst_rise1", 0, 1'b1, t_r1);
        wait_sig("arst_valid", 1, 1'b1, t_v);
        wait_sig("arst_rise2", 0, 1'b1, t_r2);
        #1 rst_n = 1'b0;
        #1;
        check("arst_flags", {bus.cnvst, bus.dout_valid, overrun, timeout_err, busy}, 0);
        check("arst_dout", bus.dout, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
